// File: rtl/vga_capture_monitor.sv
// -----------------------------------------------------------------------------
// vga_capture_monitor
//
// Receive-side checker for a VGA-style pixel stream. HS, VS and rgb are
// sampled on the pixel clock. Pixel coordinates are rebuilt using only the
// sync edges. Line and frame timing is checked against the configured mode
// (640x480@60 by default). The block reports lock, per-pixel data and
// timing violations.
//
// Ports
//   clk          in   1   pixel clock
//   reset        in   1   synchronous, active-low reset
//   HS           in   1   horizontal sync (asserted level = SYNC_POL)
//   VS           in   1   vertical sync   (asserted level = SYNC_POL)
//   rgb          in   8   pixel data
//   locked       out  1   line and frame timing locked
//   pix_valid    out  1   pix_* describes a visible pixel while locked
//   pix_x        out  11  recovered column of the sample on pix_rgb
//   pix_y        out  11  recovered row of the sample on pix_rgb
//   pix_rgb      out  8   rgb of that sample
//   frame_start  out  1   pulse together with pix_valid at x=0, y=0
//   err          out  1   one-cycle pulse on a timing violation while locked
//   err_cnt      out  8   saturating violation count
//
// Latency: a sample presented before edge N is registered at edge N and is
// visible on the outputs after edge N+1.
// -----------------------------------------------------------------------------
module vga_capture_monitor #(
  parameter int H_ACTIVE     = 640,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_LEN   = 96,
  parameter int V_ACTIVE     = 480,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC_START = 490,
  parameter int SYNC_POL     = 0,
  parameter int LOCK_LINES   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HS,
  input  logic        VS,
  input  logic [7:0]  rgb,
  output logic        locked,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic [7:0]  pix_rgb,
  output logic        frame_start,
  output logic        err,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    SEARCH,
    H_ALIGN,
    V_ALIGN,
    V_CHECK,
    LOCKED
  } state_t;

  localparam logic [10:0] X_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] X_HS_RISE = 11'(H_SYNC_START);
  localparam logic [10:0] X_HS_FALL = 11'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [10:0] X_ACT     = 11'(H_ACTIVE);
  localparam logic [10:0] Y_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] Y_VS_RISE = 11'(V_SYNC_START);
  localparam logic [10:0] Y_VS_FALL = 11'(V_SYNC_START + 2);
  localparam logic [10:0] Y_ACT     = 11'(V_ACTIVE);
  localparam logic [7:0]  LOCK_N    = 8'(LOCK_LINES);
  localparam logic        SYNC_LVL  = (SYNC_POL != 0);

  // Input stage. Syncs are stored as "asserted" flags, not raw levels, so
  // that the all-zero reset value means "not asserted" for either polarity.
  logic       hs_act_q, hs_act_d;
  logic       vs_act_q, vs_act_d;
  logic       hs_prev_q, hs_prev_d;
  logic       vs_prev_q, vs_prev_d;
  logic [7:0] rgb_q, rgb_d;

  // Tracking state.
  state_t      state_q, state_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic        rise_ok_q, rise_ok_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;

  // Output registers.
  logic [7:0]  pix_rgb_q, pix_rgb_d;
  logic        pix_valid_q, pix_valid_d;
  logic        frame_start_q, frame_start_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        locked_q, locked_d;

  // Combinational helpers.
  logic        hs_rise, hs_fall, vs_rise, vs_fall, vs_edge;
  logic [10:0] x_pred, y_pred;
  logic        bad_line, good_line, violation;

  // NOTE: every signal written here gets a default value first. Then no
  //       path through the case leaves one unassigned, so no latch is inferred.
  always_comb begin
    hs_act_d  = (HS == SYNC_LVL);
    vs_act_d  = (VS == SYNC_LVL);
    rgb_d     = rgb;
    hs_prev_d = hs_act_q;
    vs_prev_d = vs_act_q;

    hs_rise = hs_act_q & ~hs_prev_q;
    hs_fall = ~hs_act_q & hs_prev_q;
    vs_rise = vs_act_q & ~vs_prev_q;
    vs_fall = ~vs_act_q & vs_prev_q;
    vs_edge = vs_rise | vs_fall;

    // Free-running prediction for this sample, before any sync reload.
    x_pred = (x_q == X_LAST) ? 11'd0 : x_q + 11'd1;
    y_pred = y_q;
    if (!hs_rise && (x_q == X_LAST)) begin
      y_pred = (y_q == Y_LAST) ? 11'd0 : y_q + 11'd1;
    end

    // The HS reload wins. Every VS check below uses the reloaded x (x_d).
    x_d = hs_rise ? X_HS_RISE : x_pred;
    y_d = y_pred;

    // A rise off the predicted column means the line length was wrong. A
    // fall off the predicted column means the pulse width was wrong.
    bad_line  = (hs_rise && (x_pred != X_HS_RISE)) ||
                (hs_fall && (x_pred != X_HS_FALL));
    good_line = hs_fall && rise_ok_q && (x_pred == X_HS_FALL);

    rise_ok_d = rise_ok_q;
    if (hs_rise) begin
      rise_ok_d = (x_pred == X_HS_RISE);
    end

    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    violation  = 1'b0;

    case (state_q)
      SEARCH: begin
        if (hs_rise) begin
          state_d    = H_ALIGN;
          good_cnt_d = 8'd0;
          // The first pulse only sets the phase of x. It was not checked.
          rise_ok_d  = 1'b0;
        end
      end
      H_ALIGN: begin
        if (bad_line) begin
          good_cnt_d = 8'd0;
        end else if (good_line) begin
          good_cnt_d = good_cnt_q + 8'd1;
          if (good_cnt_d >= LOCK_N) begin
            state_d = V_ALIGN;
          end
        end
      end
      V_ALIGN: begin
        if (vs_rise) begin
          y_d = Y_VS_RISE;
        end
        if (vs_edge && (x_d != 11'd0)) begin
          state_d = SEARCH;
        end else if (vs_rise) begin
          state_d = V_CHECK;
        end else if (bad_line) begin
          state_d = SEARCH;
        end
      end
      V_CHECK: begin
        if (bad_line) begin
          state_d = SEARCH;
        end else if (vs_rise) begin
          // A full frame of free counting must land back on the sync row.
          state_d = ((x_d == 11'd0) && (y_pred == Y_VS_RISE)) ? LOCKED : SEARCH;
        end
      end
      LOCKED: begin
        violation = bad_line ||
                    (vs_edge && (x_d != 11'd0)) ||
                    (vs_rise && (y_d != Y_VS_RISE)) ||
                    (vs_fall && (y_d != Y_VS_FALL));
        if (violation) begin
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase

    err_d         = violation;
    err_cnt_d     = (violation && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    locked_d      = (state_d == LOCKED);
    pix_valid_d   = locked_d && (x_d < X_ACT) && (y_d < Y_ACT);
    frame_start_d = pix_valid_d && (x_d == 11'd0) && (y_d == 11'd0);
    pix_rgb_d     = rgb_q;
  end

  // NOTE: registers are updated with non-blocking assignments. All flops
  //       then sample the values from before the edge, whatever the order
  //       of the statements. Every flop is plain state with a defined value
  //       after reset. There is no memory array here to leave unreset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hs_act_q      <= 1'b0;
      vs_act_q      <= 1'b0;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      rgb_q         <= 8'd0;
      state_q       <= SEARCH;
      good_cnt_q    <= 8'd0;
      rise_ok_q     <= 1'b0;
      x_q           <= 11'd0;
      y_q           <= 11'd0;
      pix_rgb_q     <= 8'd0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      err_q         <= 1'b0;
      err_cnt_q     <= 8'd0;
      locked_q      <= 1'b0;
    end else begin
      hs_act_q      <= hs_act_d;
      vs_act_q      <= vs_act_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      rgb_q         <= rgb_d;
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      rise_ok_q     <= rise_ok_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pix_rgb_q     <= pix_rgb_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      err_q         <= err_d;
      err_cnt_q     <= err_cnt_d;
      locked_q      <= locked_d;
    end
  end

  assign locked      = locked_q;
  assign pix_valid   = pix_valid_q;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign pix_rgb     = pix_rgb_q;
  assign frame_start = frame_start_q;
  assign err         = err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_capture_monitor.sv
// -----------------------------------------------------------------------------
// tb_vga_capture_monitor
//
// Directed bench for vga_capture_monitor. It uses a scaled-down video mode so
// that many frames and relocks fit in a short run. The mode is a 10-clock
// line with 5 visible pixels and a 7-line frame with 3 visible lines. The
// bench generates sync and pixel data from its own raster position. It then
// compares the recovered coordinates and data with that position, one sample
// later.
// -----------------------------------------------------------------------------
module tb_vga_capture_monitor;

  localparam int   HA  = 5;
  localparam int   HT  = 10;
  localparam int   HSS = 6;
  localparam int   HSL = 2;
  localparam int   VA  = 3;
  localparam int   VT  = 7;
  localparam int   VSS = 4;
  localparam int   LL  = 2;
  localparam int   FR  = HT * VT;
  localparam logic POL = 1'b0;

  logic        clk;
  logic        reset;
  logic        HS;
  logic        VS;
  logic [7:0]  rgb;
  logic        locked;
  logic        pix_valid;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic [7:0]  pix_rgb;
  logic        frame_start;
  logic        err;
  logic [7:0]  err_cnt;

  vga_capture_monitor #(
    .H_ACTIVE     (HA),
    .H_TOTAL      (HT),
    .H_SYNC_START (HSS),
    .H_SYNC_LEN   (HSL),
    .V_ACTIVE     (VA),
    .V_TOTAL      (VT),
    .V_SYNC_START (VSS),
    .SYNC_POL     (0),
    .LOCK_LINES   (LL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .HS          (HS),
    .VS          (VS),
    .rgb         (rgb),
    .locked      (locked),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_rgb     (pix_rgb),
    .frame_start (frame_start),
    .err         (err),
    .err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Raster position of the next sample to drive, and of the last one driven.
  int gx, gy, p_x, p_y;
  int vs_off;
  bit vs_last;
  bit chk;
  int valid_cnt, fs_cnt, err_pulses, vs_rises;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive the current raster position for one clock. Then check the outputs,
  // which now describe the sample driven one call earlier.
  task automatic send_one();
    bit   hs_a, vs_a;
    int   p;
    logic vis_exp;
    hs_a = (gx >= HSS) && (gx < HSS + HSL);
    p    = gy * HT + gx;
    vs_a = (p >= VSS * HT + vs_off) && (p < (VSS + 2) * HT + vs_off);
    HS   = hs_a ? POL : ~POL;
    VS   = vs_a ? POL : ~POL;
    rgb  = 8'(gx ^ gy);
    if (vs_a && !vs_last) vs_rises++;
    vs_last = vs_a;
    @(posedge clk);
    #1;
    if (chk) begin
      vis_exp = locked && (p_x < HA) && (p_y < VA);
      check("pix_valid", 32'(pix_valid), 32'(vis_exp));
      check("frame_start", 32'(frame_start), 32'(vis_exp && (p_x == 0) && (p_y == 0)));
      if (pix_valid === 1'b1) begin
        check("pix_x", 32'(pix_x), 32'(p_x));
        check("pix_y", 32'(pix_y), 32'(p_y));
        check("pix_rgb", 32'(pix_rgb), 32'(8'(p_x ^ p_y)));
        check("pix_rgb_xor", 32'(pix_rgb), 32'(pix_x[7:0] ^ pix_y[7:0]));
      end
    end
    if (pix_valid === 1'b1) valid_cnt++;
    if (frame_start === 1'b1) fs_cnt++;
    if (err === 1'b1) err_pulses++;
    p_x = gx;
    p_y = gy;
  endtask

  task automatic send_adv();
    send_one();
    gx++;
    if (gx == HT) begin
      gx = 0;
      gy = (gy == VT - 1) ? 0 : gy + 1;
    end
  endtask

  task automatic wait_lock(input int budget, input string tag);
    int n = 0;
    while (locked !== 1'b1 && n < budget) begin
      send_adv();
      n++;
    end
    check(tag, 32'(locked), 32'd1);
    check({tag, "_x"}, 32'(pix_x), 32'd0);
    check({tag, "_y"}, 32'(pix_y), 32'(VSS));
  endtask

  task automatic wait_err(input int budget, input int exp_cnt, input string tag);
    int n = 0;
    while (err !== 1'b1 && n < budget) begin
      send_adv();
      n++;
    end
    check(tag, 32'(err), 32'd1);
    check({tag, "_cnt"}, 32'(err_cnt), 32'(exp_cnt));
    send_adv();
    check({tag, "_pulse"}, 32'(err), 32'd0);
    check({tag, "_unlock"}, 32'(locked), 32'd0);
    chk = 1'b1;
  endtask

  // Let one line run one clock longer than HT by sending its last sample twice.
  task automatic stretch_line(input bool_at_y1);
    int n = 0;
    chk = 1'b0;
    while (!((gx == HT - 1) && (!bool_at_y1 || gy == 1)) && n < 2 * FR) begin
      send_adv();
      n++;
    end
    send_one();
  endtask

  initial begin
    int n;
    // 1: reset held with idle syncs.
    chk     = 1'b0;
    reset   = 1'b0;
    HS      = ~POL;
    VS      = ~POL;
    rgb     = 8'd0;
    gx      = 0;
    gy      = 0;
    p_x     = 0;
    p_y     = 0;
    vs_off  = 0;
    vs_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_pix_x", 32'(pix_x), 32'd0);

    // 2: ideal stream. Lock comes on the second VS rise, then two clean frames.
    reset    = 1'b1;
    chk      = 1'b1;
    vs_rises = 0;
    wait_lock(4 * FR, "lock_t2");
    check("lock_vs_edges", 32'(vs_rises), 32'd2);
    valid_cnt  = 0;
    fs_cnt     = 0;
    err_pulses = 0;
    repeat (2 * FR) send_adv();
    check("valid_per_2frames", 32'(valid_cnt), 32'(2 * HA * VA));
    check("frame_starts", 32'(fs_cnt), 32'd2);
    check("no_err_ideal", 32'(err_pulses), 32'd0);
    check("still_locked", 32'(locked), 32'd1);

    // 3: one line one clock too long.
    stretch_line(1'b1);
    wait_err(3 * HT, 1, "t3_err");
    wait_lock(3 * FR, "relock_t3");
    check("t3_cnt_kept", 32'(err_cnt), 32'd1);

    // 4: VS rise moved to x=5. The shift is switched outside the VS pulse.
    n = 0;
    while (gy != 0 && n < FR) begin send_adv(); n++; end
    vs_off = 5;
    wait_err(2 * FR, 2, "t4_err");
    n = 0;
    while (gy != 0 && n < FR) begin send_adv(); n++; end
    vs_off = 0;
    wait_lock(4 * FR, "relock_t4");

    // 5: 300 more violations. The count must saturate at 255.
    err_pulses = 0;
    for (int i = 0; i < 300; i++) begin
      stretch_line(1'b0);
      wait_err(3 * HT, (3 + i > 255) ? 255 : 3 + i, "t5_err");
      wait_lock(5 * FR, "relock_t5");
    end
    check("t5_pulses", 32'(err_pulses), 32'd300);
    check("t5_saturated", 32'(err_cnt), 32'd255);

    // 6: reset mid-frame while locked, on a visible row.
    n = 0;
    while (!(pix_valid === 1'b1 && pix_y == 11'd2) && n < 2 * FR) begin send_adv(); n++; end
    check("t6_mid_frame", 32'(pix_y), 32'd2);
    reset = 1'b0;
    send_adv();
    check("t6_locked", 32'(locked), 32'd0);
    check("t6_pix_valid", 32'(pix_valid), 32'd0);
    check("t6_pix_x", 32'(pix_x), 32'd0);
    check("t6_pix_y", 32'(pix_y), 32'd0);
    check("t6_pix_rgb", 32'(pix_rgb), 32'd0);
    check("t6_frame_start", 32'(frame_start), 32'd0);
    check("t6_err", 32'(err), 32'd0);
    check("t6_err_cnt", 32'(err_cnt), 32'd0);
    reset = 1'b1;
    wait_lock(4 * FR, "relock_t6");
    check("t6_cnt_restart", 32'(err_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
